// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding selects
// and divider sequencer state encodings.
package hazard_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/hazard_ctrl_div_seq.sv
// Multi-cycle divider sequencer: tracks how long HI/LO is in flight so that
// HI/LO consumers in decode can be held until the result is written.
module div_seq
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNTW       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic div_start_e,
    output logic div_busy,
    output logic div_done
);

    logic [1:0]      state;
    logic [CNTW-1:0] count;

    // A start while BUSY is ignored; decode stalls should make it impossible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DIV_IDLE;
            count <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_start_e) begin
                        state <= DIV_BUSY;
                        count <= CNTW'(DIV_CYCLES - 1);
                    end
                end
                DIV_BUSY: begin
                    if (count == '0) begin
                        state <= DIV_DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (div_start_e) begin
                        state <= DIV_BUSY;
                        count <= CNTW'(DIV_CYCLES - 1);
                    end else begin
                        state <= DIV_IDLE;
                    end
                end
                default: begin
                    state <= DIV_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign div_busy = (state == DIV_BUSY);
    assign div_done = (state == DIV_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use / branch / divide
// stalls. Define HAZARD_DIV_SEQ_EN to build the multi-cycle divider sequencer.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REGW       = 5,
    parameter int DIV_CYCLES = 32,
    parameter int CNTW       = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] rs_d,
    input  logic [REGW-1:0] rt_d,
    input  logic            branch_d,
    input  logic            jr_d,
    input  logic            hilo_d,
    input  logic [REGW-1:0] rs_e,
    input  logic [REGW-1:0] rt_e,
    input  logic [REGW-1:0] writereg_e,
    input  logic            regwrite_e,
    input  logic            memtoreg_e,
    input  logic            div_start_e,
    input  logic [REGW-1:0] writereg_m,
    input  logic            regwrite_m,
    input  logic            memtoreg_m,
    input  logic [REGW-1:0] writereg_w,
    input  logic            regwrite_w,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_e,
    output logic            forward_ad,
    output logic            forward_bd,
    output logic [1:0]      forward_ae,
    output logic [1:0]      forward_be,
    output logic            div_busy,
    output logic            div_done
);

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [REGW-1:0] src,
                                       input logic [REGW-1:0] dst,
                                       input logic            we);
        return we && (dst != '0) && (dst == src);
    endfunction

    logic lw_stall;
    logic branch_stall;
    logic div_stall;
    logic uses_rs;
    logic uses_rt;

    always_comb begin
        forward_ae = FWD_NONE;
        if (reg_match(rs_e, writereg_m, regwrite_m)) begin
            forward_ae = FWD_MEM;
        end else if (reg_match(rs_e, writereg_w, regwrite_w)) begin
            forward_ae = FWD_WB;
        end
    end

    always_comb begin
        forward_be = FWD_NONE;
        if (reg_match(rt_e, writereg_m, regwrite_m)) begin
            forward_be = FWD_MEM;
        end else if (reg_match(rt_e, writereg_w, regwrite_w)) begin
            forward_be = FWD_WB;
        end
    end

    assign forward_ad = reg_match(rs_d, writereg_m, regwrite_m);
    assign forward_bd = reg_match(rt_d, writereg_m, regwrite_m);

    assign lw_stall = reg_match(rs_d, writereg_e, memtoreg_e)
                    | reg_match(rt_d, writereg_e, memtoreg_e);

    // jr only reads rs, so a pending write to rt must not hold it.
    assign uses_rs = branch_d | jr_d;
    assign uses_rt = branch_d;

    assign branch_stall = (uses_rs & reg_match(rs_d, writereg_e, regwrite_e))
                        | (uses_rt & reg_match(rt_d, writereg_e, regwrite_e))
                        | (uses_rs & reg_match(rs_d, writereg_m, memtoreg_m))
                        | (uses_rt & reg_match(rt_d, writereg_m, memtoreg_m));

`ifdef HAZARD_DIV_SEQ_EN
    div_seq #(
        .DIV_CYCLES(DIV_CYCLES),
        .CNTW      (CNTW)
    ) u_div_seq (
        .clk        (clk),
        .reset      (reset),
        .div_start_e(div_start_e),
        .div_busy   (div_busy),
        .div_done   (div_done)
    );

    assign div_stall = hilo_d & (div_busy | div_start_e);
`else
    logic unused_div_cfg;

    assign div_busy       = 1'b0;
    assign div_done       = 1'b0;
    assign div_stall      = 1'b0;
    assign unused_div_cfg = ^{clk, reset, div_start_e, hilo_d} ^ (DIV_CYCLES > CNTW);
`endif

    assign stall_f = lw_stall | branch_stall | div_stall;
    assign stall_d = stall_f;
    assign flush_e = stall_f;

endmodule
